// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpu_pkg
// Brief   : Shared scheduler state type, layer constants and header field map.
// Rev     : 1.0
// ============================================================================
package gpu_pkg;

    localparam int c_NUM_LAYERS     = 16;
    localparam int c_HDR_W          = 128;
    localparam int c_HDR_POPULATED  = 0;
    localparam int c_HDR_IS_SPRITE  = 1;
    localparam int c_HDR_ID_LSB     = 8;
    localparam int c_HDR_ID_MSB     = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_RD   = 3'd1,
        HDR_WAIT = 3'd2,
        EVAL     = 3'd3,
        ISSUE    = 3'd4,
        DONE     = 3'd5
    } sched_state_t;

    function automatic logic [7:0] hdr_layer_id(input logic [c_HDR_W-1:0] hdr);
        return hdr[c_HDR_ID_MSB:c_HDR_ID_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : layer_scheduler_if
// Brief   : Valid/ready fetch-request channel from the scheduler to the fetch unit.
// Rev     : 1.0
// ============================================================================
interface layer_scheduler_if #(
    parameter int LAYER_IDX_W = 4
);

    logic                   fetchValid;
    logic                   fetchReady;
    logic                   fetchRam;
    logic                   fetchFlash;
    logic [7:0]             fetchLayerID;
    logic [LAYER_IDX_W-1:0] fetchLayerIdx;

    modport master (
        output fetchValid,
        output fetchRam,
        output fetchFlash,
        output fetchLayerID,
        output fetchLayerIdx,
        input  fetchReady
    );

    modport slave (
        input  fetchValid,
        input  fetchRam,
        input  fetchFlash,
        input  fetchLayerID,
        input  fetchLayerIdx,
        output fetchReady
    );

endinterface
`default_nettype wire

// File: rtl/layer_fetch_req_reg.sv
`default_nettype none
// ============================================================================
// Module  : layer_fetch_req_reg
// Brief   : Holding register for one fetch request; cleared on handshake or abort.
// Rev     : 1.0
// ============================================================================
module layer_fetch_req_reg #(
    parameter int LAYER_IDX_W = 4
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    load,
    input  wire                    abort,
    input  wire                    ram,
    input  wire                    flash,
    input  wire  [7:0]             layerID,
    input  wire  [LAYER_IDX_W-1:0] layerIdx,
    output logic                   taken,
    layer_scheduler_if.master      fetch
);

    logic                   r_valid;
    logic                   r_ram;
    logic                   r_flash;
    logic [7:0]             r_layer_id;
    logic [LAYER_IDX_W-1:0] r_layer_idx;

    // Abort withdraws the request even if the fetch unit is asserting ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_ram       <= 1'b0;
            r_flash     <= 1'b0;
            r_layer_id  <= '0;
            r_layer_idx <= '0;
        end else if (abort) begin
            r_valid     <= 1'b0;
        end else if (load) begin
            r_valid     <= 1'b1;
            r_ram       <= ram;
            r_flash     <= flash;
            r_layer_id  <= layerID;
            r_layer_idx <= layerIdx;
        end else if (taken) begin
            r_valid     <= 1'b0;
        end
    end

    assign taken               = r_valid && fetch.fetchReady;
    assign fetch.fetchValid    = r_valid;
    assign fetch.fetchRam      = r_ram;
    assign fetch.fetchFlash    = r_flash;
    assign fetch.fetchLayerID  = r_layer_id;
    assign fetch.fetchLayerIdx = r_layer_idx;

endmodule
`default_nettype wire

// File: rtl/layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : layer_scheduler
// Brief   : Per-pixel layer walker: header read, ALU evaluation, fetch issue.
// Rev     : 1.0
// ============================================================================
module layer_scheduler
    import gpu_pkg::*;
#(
    parameter int NUM_LAYERS  = c_NUM_LAYERS,
    parameter int LAYER_IDX_W = $clog2(c_NUM_LAYERS),
    parameter int HDR_W       = c_HDR_W
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    pixelValid,
    output logic                   pixelReady,
    input  wire  [10:0]            pixelX,
    input  wire  [10:0]            pixelY,
    input  wire  [LAYER_IDX_W:0]   layerCount,
    input  wire                    abort,
    output logic                   hdrRdEn,
    output logic [LAYER_IDX_W-1:0] hdrAddr,
    input  wire  [HDR_W-1:0]       hdrData,
    output logic [HDR_W-1:0]       currLayerHeader,
    output logic [10:0]            aluPixelX,
    output logic [10:0]            aluPixelY,
    input  wire                    aluReadRamEn,
    input  wire                    aluReadFlashEn,
    input  wire  [7:0]             aluLayerID,
    layer_scheduler_if.master      fetch,
    output logic                   pixelDone,
    output logic                   busy
);

    localparam logic [LAYER_IDX_W:0]   c_MAX_COUNT = (LAYER_IDX_W+1)'(NUM_LAYERS);
    localparam logic [LAYER_IDX_W-1:0] c_LAST_IDX  = LAYER_IDX_W'(NUM_LAYERS - 1);

    sched_state_t           r_state;
    logic [LAYER_IDX_W-1:0] r_idx;
    logic [LAYER_IDX_W:0]   r_count;
    logic                   r_hdr_rd_en;
    logic [LAYER_IDX_W-1:0] r_hdr_addr;
    logic [HDR_W-1:0]       r_curr_hdr;
    logic [10:0]            r_pix_x;
    logic [10:0]            r_pix_y;
    logic                   r_pixel_done;

    logic [LAYER_IDX_W:0]   w_count_clamped;
    logic                   w_alu_req;
    logic                   w_abort;
    logic                   w_load;
    logic                   w_taken;
    logic                   w_advance;
    logic                   w_last;

    assign w_count_clamped = (layerCount > c_MAX_COUNT) ? c_MAX_COUNT : layerCount;
    assign w_alu_req       = aluReadRamEn | aluReadFlashEn;
    assign w_abort         = abort && (r_state != IDLE);
    assign w_load          = (r_state == EVAL) && w_alu_req && !w_abort;
    assign w_advance       = ((r_state == EVAL) && !w_alu_req) || ((r_state == ISSUE) && w_taken);
    // The index guard keeps idx from wrapping even if count were corrupted.
    assign w_last          = ({1'b0, r_idx} == (r_count - 1'b1)) || (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_count      <= '0;
            r_hdr_rd_en  <= 1'b0;
            r_hdr_addr   <= '0;
            r_curr_hdr   <= '0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pixel_done <= 1'b0;
        end else begin
            r_hdr_rd_en  <= 1'b0;
            r_pixel_done <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (pixelValid && !abort) begin
                            r_pix_x <= pixelX;
                            r_pix_y <= pixelY;
                            r_count <= w_count_clamped;
                            r_idx   <= '0;
                            if (w_count_clamped == '0) begin
                                r_state      <= DONE;
                                r_pixel_done <= 1'b1;
                            end else begin
                                r_state     <= HDR_RD;
                                r_hdr_rd_en <= 1'b1;
                                r_hdr_addr  <= '0;
                            end
                        end
                    end
                    HDR_RD: begin
                        r_state <= HDR_WAIT;
                    end
                    HDR_WAIT: begin
                        r_curr_hdr <= hdrData;
                        r_state    <= EVAL;
                    end
                    EVAL, ISSUE: begin
                        if (w_advance) begin
                            if (w_last) begin
                                r_state      <= DONE;
                                r_pixel_done <= 1'b1;
                            end else begin
                                r_idx       <= r_idx + 1'b1;
                                r_hdr_addr  <= r_idx + 1'b1;
                                r_hdr_rd_en <= 1'b1;
                                r_state     <= HDR_RD;
                            end
                        end else if (r_state == EVAL) begin
                            r_state <= ISSUE;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    layer_fetch_req_reg #(
        .LAYER_IDX_W (LAYER_IDX_W)
    ) u_fetch_req (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .abort    (w_abort),
        .ram      (aluReadRamEn),
        .flash    (aluReadFlashEn),
        .layerID  (aluLayerID),
        .layerIdx (r_idx),
        .taken    (w_taken),
        .fetch    (fetch)
    );

    assign pixelReady      = (r_state == IDLE);
    assign busy            = (r_state != IDLE);
    assign hdrRdEn         = r_hdr_rd_en;
    assign hdrAddr         = r_hdr_addr;
    assign currLayerHeader = r_curr_hdr;
    assign aluPixelX       = r_pix_x;
    assign aluPixelY       = r_pix_y;
    assign pixelDone       = r_pixel_done;

endmodule
`default_nettype wire

// File: tb/tb_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_layer_scheduler
// Brief   : Randomized self-checking bench with a per-pixel reference model.
// Rev     : 1.0
// ============================================================================
module tb_layer_scheduler;

    localparam int NL = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pixelValid = 1'b0;
    logic [10:0]  pixelX = '0;
    logic [10:0]  pixelY = '0;
    logic [4:0]   layerCount = '0;
    logic         abort = 1'b0;
    logic [127:0] hdrData = '0;

    logic         pixelReady, hdrRdEn, pixelDone, busy;
    logic [3:0]   hdrAddr;
    logic [127:0] currLayerHeader;
    logic [10:0]  aluPixelX, aluPixelY;
    logic         aluReadRamEn, aluReadFlashEn;
    logic [7:0]   aluLayerID;

    logic [127:0] hdr_mem [NL];
    int           n_vec = 0;
    int           n_err = 0;
    int           ready_mode = 0;
    int           stall_cnt = 0;
    bit           ready_force = 1'b0;

    layer_scheduler_if #(.LAYER_IDX_W(4)) fif ();

    layer_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pixelValid      (pixelValid),
        .pixelReady      (pixelReady),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .layerCount      (layerCount),
        .abort           (abort),
        .hdrRdEn         (hdrRdEn),
        .hdrAddr         (hdrAddr),
        .hdrData         (hdrData),
        .currLayerHeader (currLayerHeader),
        .aluPixelX       (aluPixelX),
        .aluPixelY       (aluPixelY),
        .aluReadRamEn    (aluReadRamEn),
        .aluReadFlashEn  (aluReadFlashEn),
        .aluLayerID      (aluLayerID),
        .fetch           (fif),
        .pixelDone       (pixelDone),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // ALU: bit0 populated, bit1 needs RAM, bit2 needs flash, [15:8] layer ID.
    assign aluReadRamEn   = currLayerHeader[0] & currLayerHeader[1];
    assign aluReadFlashEn = currLayerHeader[0] & currLayerHeader[2];
    assign aluLayerID     = currLayerHeader[15:8];

    // Header memory: data only valid the cycle after a read strobe, garbage otherwise.
    always @(posedge clk)
        hdrData <= hdrRdEn ? hdr_mem[hdrAddr] : {$urandom, $urandom, $urandom, $urandom};

    // Fetch-unit ready: 0 tied high, 1 random, 2 forced, 3 stall five cycles per request.
    initial begin
        fif.fetchReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: fif.fetchReady = 1'b1;
                1: fif.fetchReady = 1'($urandom_range(0, 1));
                2: fif.fetchReady = ready_force;
                default: begin
                    if (fif.fetchValid) begin
                        fif.fetchReady = (stall_cnt >= 5);
                        stall_cnt++;
                    end else begin
                        stall_cnt = 0;
                        fif.fetchReady = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic fill_hdrs(input bit none_populated);
        for (int i = 0; i < NL; i++) begin
            hdr_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            if (none_populated) hdr_mem[i][0] = 1'b0;
        end
    endtask

    task automatic clear_hdrs();
        for (int i = 0; i < NL; i++) hdr_mem[i] = '0;
    endtask

    task automatic start_pixel(input int cnt, input logic [10:0] x, input logic [10:0] y);
        @(posedge clk);
        #1;
        pixelValid = 1'b1;
        pixelX     = x;
        pixelY     = y;
        layerCount = 5'(cnt);
        @(negedge clk);
        check_eq("pixel_ready", pixelReady, 1);
        @(posedge clk);
        #1;
        pixelValid = 1'b0;
        pixelX     = ~x;
        pixelY     = ~y;
        layerCount = 5'($urandom);
    endtask

    task automatic run_pixel(input int cnt, input logic [10:0] x, input logic [10:0] y);
        int          n, k, lat, stalls;
        bit          done, prev_stall;
        logic [13:0] cur, prev_req;
        int          reads[$];
        logic [13:0] reqs[$];
        logic [13:0] exp_reqs[$];
        n = (cnt > NL) ? NL : cnt;
        for (int i = 0; i < n; i++)
            if (hdr_mem[i][0] && (hdr_mem[i][1] || hdr_mem[i][2]))
                exp_reqs.push_back({hdr_mem[i][1], hdr_mem[i][2], hdr_mem[i][15:8], 4'(i)});
        k = exp_reqs.size();
        start_pixel(cnt, x, y);
        lat = 0; stalls = 0; done = 1'b0; prev_stall = 1'b0; prev_req = '0;
        while (!done && lat < 2000) begin
            @(negedge clk);
            lat++;
            cur = {fif.fetchRam, fif.fetchFlash, fif.fetchLayerID, fif.fetchLayerIdx};
            if (lat == 1) begin
                check_eq("alu_x", aluPixelX, x);
                check_eq("alu_y", aluPixelY, y);
            end
            if (hdrRdEn) reads.push_back(int'(hdrAddr));
            if (prev_stall) begin
                check_eq("hold_valid", fif.fetchValid, 1);
                check_eq("hold_fields", cur, prev_req);
            end
            if (fif.fetchValid && fif.fetchReady) reqs.push_back(cur);
            if (fif.fetchValid && !fif.fetchReady) stalls++;
            prev_stall = fif.fetchValid && !fif.fetchReady;
            prev_req   = cur;
            done       = pixelDone;
        end
        check_eq("done_seen", done, 1);
        check_eq("latency", lat, 1 + 3 * n + k + stalls);
        check_eq("num_reads", reads.size(), n);
        for (int i = 0; i < reads.size() && i < n; i++) check_eq("hdr_addr", reads[i], i);
        check_eq("num_reqs", reqs.size(), k);
        for (int i = 0; i < reqs.size() && i < k; i++) check_eq("req", reqs[i], exp_reqs[i]);
        if (ready_mode == 3) check_eq("stalls", stalls, 5 * k);
        if (n > 0) check_eq("hdr_hold", currLayerHeader, hdr_mem[n-1]);
        @(negedge clk);
        check_eq("done_pulse", pixelDone, 0);
        check_eq("ready_back", pixelReady, 1);
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!fif.fetchValid && g < 200) begin
            @(negedge clk);
            g++;
        end
        check_eq("valid_seen", fif.fetchValid, 1);
    endtask

    task automatic abort_in_issue();
        clear_hdrs();
        hdr_mem[0] = 128'h0703;
        ready_mode = 2;
        ready_force = 1'b0;
        start_pixel(2, 11'($urandom), 11'($urandom));
        wait_valid();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ready_force = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", fif.fetchValid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", pixelReady, 1);
        repeat (4) begin
            check_eq("abort_no_done", pixelDone, 0);
            check_eq("abort_no_rd", hdrRdEn, 0);
            @(negedge clk);
        end
    endtask

    task automatic abort_in_idle();
        @(posedge clk);
        #1;
        pixelValid = 1'b1;
        abort      = 1'b1;
        layerCount = 5'd3;
        @(posedge clk);
        #1;
        pixelValid = 1'b0;
        abort      = 1'b0;
        @(negedge clk);
        check_eq("idle_abort_busy", busy, 0);
        check_eq("idle_abort_rd", hdrRdEn, 0);
    endtask

    task automatic async_reset_in_issue();
        clear_hdrs();
        hdr_mem[0] = 128'h0505;
        ready_mode = 2;
        ready_force = 1'b0;
        start_pixel(1, 11'($urandom), 11'($urandom));
        wait_valid();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", fif.fetchValid, 0);
        check_eq("arst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_ready", pixelReady, 1);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_hdrs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_pixel_ready", pixelReady, 1);
        check_eq("rst_hdr_rd", hdrRdEn, 0);
        check_eq("rst_fetch_valid", fif.fetchValid, 0);
        check_eq("rst_pixel_done", pixelDone, 0);
        check_eq("rst_hdr", currLayerHeader, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_alu_x", aluPixelX, 0);

        fill_hdrs(1'b1);
        ready_mode = 0;
        run_pixel(3, 11'd100, 11'd50);

        clear_hdrs();
        hdr_mem[1] = 128'h0703;
        ready_mode = 3;
        run_pixel(2, 11'($urandom), 11'($urandom));

        ready_mode = 0;
        run_pixel(0, 11'($urandom), 11'($urandom));

        fill_hdrs(1'b0);
        run_pixel(20, 11'($urandom), 11'($urandom));

        abort_in_issue();
        abort_in_idle();
        fill_hdrs(1'b0);
        ready_mode = 0;
        run_pixel(4, 11'($urandom), 11'($urandom));

        repeat (25) begin
            fill_hdrs(1'b0);
            ready_mode = $urandom_range(0, 1);
            run_pixel($urandom_range(0, 20), 11'($urandom), 11'($urandom));
        end

        async_reset_in_issue();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Per-pixel sequencer for the ALU stage.
- Accepts a pixel coordinate and walks the active layers in order. For each layer it reads the 128-bit layer header from header memory and drives it, with the pixel, into the ALU address stage.
- It then samples the ALU's readRamEn/readFlashEn/layerID and, when either enable is set, issues one fetch request to the fetch unit over a valid/ready handshake.
- Sits between the pixel counter and the ALU/fetch pipeline stages.

Parameters:
NUM_LAYERS, 16, maximum layers per pixel; header memory depth.
LAYER_IDX_W, 4, width of the layer index; equals clog2(NUM_LAYERS).
HDR_W, 128, layer header width in bits.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
pixelValid  in  1  pixelX/pixelY valid.
pixelReady  out  1  scheduler can accept a pixel (high only in IDLE).
pixelX  in  11  pixel X position.
pixelY  in  11  pixel Y position.
layerCount  in  LAYER_IDX_W+1  number of active layers, 0..NUM_LAYERS; sampled on pixel accept.
abort  in  1  synchronous abort of the current pixel.
hdrRdEn  out  1  header memory read strobe.
hdrAddr  out  LAYER_IDX_W  header memory address (layer index).
hdrData  in  HDR_W  header read data; valid exactly 1 cycle after hdrRdEn.
currLayerHeader  out  HDR_W  registered header to the ALU.
aluPixelX  out  11  registered pixel X to the ALU.
aluPixelY  out  11  registered pixel Y to the ALU.
aluReadRamEn  in  1  ALU RAM read enable (combinational from currLayerHeader).
aluReadFlashEn  in  1  ALU flash read enable.
aluLayerID  in  8  ALU layer ID.
fetchValid  out  1  fetch request valid.
fetchReady  in  1  fetch unit accepts the request.
fetchRam  out  1  request includes a RAM read.
fetchFlash  out  1  request includes a flash read.
fetchLayerID  out  8  layer ID of the request.
fetchLayerIdx  out  LAYER_IDX_W  layer index of the request.
pixelDone  out  1  one-cycle pulse when all layers of the pixel have been processed.
busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE.
  - Low: hdrRdEn, fetchValid, fetchRam, fetchFlash, pixelDone, busy.
  - Zero: hdrAddr, currLayerHeader, aluPixelX/Y, fetchLayerID, fetchLayerIdx, layer index, latched layerCount.
  - pixelReady=1 after reset release.
- IDLE:
  - pixelReady=1.
  - On pixelValid: latch pixelX/Y into aluPixelX/Y, latch layerCount, set idx=0.
  - If the latched count is 0, go to DONE; otherwise go to HDR_RD.
- HDR_RD: hdrRdEn=1, hdrAddr=idx; go to HDR_WAIT.
- HDR_WAIT: currLayerHeader<=hdrData at the end of this cycle; go to EVAL.
- EVAL: ALU outputs are valid this cycle.
  - If aluReadRamEn|aluReadFlashEn: register fetchRam/fetchFlash/fetchLayerID/fetchLayerIdx, assert fetchValid next cycle, and go to ISSUE.
  - Otherwise advance the layer.
- ISSUE:
  - fetchValid and all fetch fields are held stable until fetchValid&&fetchReady.
  - On the handshake, deassert fetchValid the next cycle and advance the layer.
- Advance: if idx==count-1, go to DONE; otherwise idx<=idx+1 and go to HDR_RD.
- DONE: pixelDone=1 for exactly one cycle; go to IDLE.
- Timing:
  - Skipped layer: 3 cycles.
  - Issued layer with fetchReady tied high: 4 cycles.
  - Pixel accept to pixelDone for N skipped layers: 3N+1 cycles.
  - count=0: pixelDone 1 cycle after accept.
- Width rules:
  - count > NUM_LAYERS is clamped to NUM_LAYERS at the latch.
  - idx never wraps past NUM_LAYERS-1.
- abort:
  - Priority over every other transition. From any non-IDLE state, go to IDLE the next cycle.
  - fetchValid drops even without fetchReady; the fetch unit must tolerate a withdrawn request.
  - No pixelDone is produced.
  - abort in IDLE with pixelValid high: the pixel is not accepted.
- Simultaneous events:
  - fetchReady while fetchValid=0 is ignored.
  - fetchReady in the same cycle as abort: abort wins; that request is counted as not taken.
- Async reset mid-ISSUE drops fetchValid immediately (asynchronous clear).
- currLayerHeader holds its last value while in IDLE.

Decomposition:
- Shared package gpu_pkg:
  - state enum: IDLE, HDR_RD, HDR_WAIT, EVAL, ISSUE, DONE.
  - Constants NUM_LAYERS, HDR_W.
  - Header field offsets: POPULATED=0, IS_SPRITE=1, ID=15:8.
- One sub-module, layer_fetch_req_reg: the valid/ready request holding register (load, hold, clear on handshake/abort).
- The FSM and counters stay in layer_scheduler.

Test Plan:
- Reset release with no stimulus: pixelReady=1; hdrRdEn, fetchValid and pixelDone all 0; currLayerHeader=0.
- layerCount=3, all headers bit0=0, pixel (100,50): hdrAddr 0,1,2 in order; no fetchValid; pixelDone exactly 10 cycles after accept.
- layerCount=2, layer1 sprite with aluReadRamEn=1, layerID=0x07, fetchReady held low 5 cycles then high: fetchValid high with fields stable (fetchRam=1, fetchFlash=0, fetchLayerID=0x07, fetchLayerIdx=1) for 6 cycles; pixelDone 1 cycle after the handshake.
- layerCount=0: pixelDone 1 cycle after accept; no hdrRdEn.
- layerCount=20 (NUM_LAYERS=16): exactly 16 header reads (addresses 0..15), then pixelDone.
- abort in ISSUE with fetchReady=0: fetchValid low the next cycle, state IDLE, no pixelDone. A following pixel runs normally from idx 0.
